// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared types and constants for the warp convergence barrier
package gpu_pkg;

  localparam int THREADS_PER_WARP = 32;
  localparam int NUM_BARRIERS     = 4;

  typedef logic [THREADS_PER_WARP-1:0] thread_mask_t;

  typedef enum logic [1:0] {
    BAR_IDLE    = 2'd0,
    BAR_ARMED   = 2'd1,
    BAR_RELEASE = 2'd2
  } bar_state_e;

endpackage

// File: rtl/gpu_barrier_slot.sv
// rtl/gpu_barrier_slot.sv - one convergence barrier: FSM plus participant and arrival masks
module gpu_barrier_slot
  import gpu_pkg::*;
#(
  parameter int THREADS = THREADS_PER_WARP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               add_en,
  input  logic [THREADS-1:0] add_mask,
  input  logic [THREADS-1:0] arrive,
  output logic               busy,
  output logic               armed,
  output logic               releasing,
  output logic [THREADS-1:0] part
);

  bar_state_e         fsm_q, fsm_n;
  logic [THREADS-1:0] part_q, part_n;
  logic [THREADS-1:0] arr_q, arr_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q  <= BAR_IDLE;
      part_q <= '0;
      arr_q  <= '0;
    end else begin
      fsm_q  <= fsm_n;
      part_q <= part_n;
      arr_q  <= arr_n;
    end
  end

  // part is held through RELEASE so the top can restore those lanes
  always_comb begin
    fsm_n  = fsm_q;
    part_n = part_q;
    arr_n  = arr_q;
    unique case (fsm_q)
      BAR_IDLE: begin
        if (add_en) begin
          fsm_n  = BAR_ARMED;
          part_n = add_mask;
          arr_n  = '0;
        end
      end
      BAR_ARMED: begin
        arr_n = arr_q | arrive;
        if (arr_n == part_q) fsm_n = BAR_RELEASE;
      end
      BAR_RELEASE: begin
        fsm_n  = BAR_IDLE;
        part_n = '0;
        arr_n  = '0;
      end
      default: begin
        fsm_n  = BAR_IDLE;
        part_n = '0;
        arr_n  = '0;
      end
    endcase
  end

  assign busy      = (fsm_q != BAR_IDLE);
  assign armed     = (fsm_q == BAR_ARMED);
  assign releasing = (fsm_q == BAR_RELEASE);
  assign part      = part_q;

endmodule

// File: rtl/gpu_convergence_barrier.sv
// rtl/gpu_convergence_barrier.sv - warp active-mask owner: barrier slots, release mux, error decode
module gpu_convergence_barrier #(
  parameter int THREADS      = gpu_pkg::THREADS_PER_WARP,
  parameter int NUM_BARRIERS = gpu_pkg::NUM_BARRIERS,
  parameter int BID_W        = $clog2(NUM_BARRIERS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    add_valid,
  input  logic [BID_W-1:0]        add_bid,
  input  logic [THREADS-1:0]      add_mask,
  input  logic                    wait_valid,
  input  logic [BID_W-1:0]        wait_bid,
  input  logic [THREADS-1:0]      wait_mask,
  output logic [THREADS-1:0]      active_mask,
  output logic [NUM_BARRIERS-1:0] barrier_busy,
  output logic                    release_valid,
  output logic [BID_W-1:0]        release_bid,
  output logic                    stall,
  output logic                    err
);

  logic [THREADS-1:0]      active_q;
  logic [THREADS-1:0]      part_v   [NUM_BARRIERS];
  logic [THREADS-1:0]      arrive_v [NUM_BARRIERS];
  logic [THREADS-1:0]      add_part, arrivals, released;
  logic [NUM_BARRIERS-1:0] busy_v, armed_v, rel_v, add_en;
  logic                    same_bid, add_ok, wait_ok, req_err, rel_any;
  logic [BID_W-1:0]        rel_bid;
  logic                    release_valid_q, err_q;
  logic [BID_W-1:0]        release_bid_q;

  // an add and a wait on the same barrier cancel each other out
  assign same_bid = add_valid && wait_valid && (add_bid == wait_bid);
  assign add_part = add_mask & active_q;
  assign add_ok   = add_valid && !same_bid && !busy_v[add_bid] && (add_part != '0);
  assign wait_ok  = wait_valid && !same_bid && armed_v[wait_bid];
  assign req_err  = (add_valid && !add_ok) || (wait_valid && (same_bid || !busy_v[wait_bid]));
  assign arrivals = wait_ok ? (wait_mask & part_v[wait_bid] & active_q) : '0;

  always_comb begin
    add_en   = '0;
    released = '0;
    rel_any  = 1'b0;
    rel_bid  = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      add_en[b]   = add_ok && (add_bid == BID_W'(b));
      arrive_v[b] = (wait_bid == BID_W'(b)) ? arrivals : '0;
      if (rel_v[b]) begin
        released = released | part_v[b];
        rel_any  = 1'b1;
        rel_bid  = BID_W'(b);
      end
    end
  end

  for (genvar g = 0; g < NUM_BARRIERS; g++) begin : g_slot
    gpu_barrier_slot #(.THREADS(THREADS)) u_slot (
      .clk       (clk),
      .reset     (reset),
      .add_en    (add_en[g]),
      .add_mask  (add_part),
      .arrive    (arrive_v[g]),
      .busy      (busy_v[g]),
      .armed     (armed_v[g]),
      .releasing (rel_v[g]),
      .part      (part_v[g])
    );
  end

  // released lanes are OR'd in last so a release beats a same-cycle park
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q        <= '1;
      release_valid_q <= 1'b0;
      release_bid_q   <= '0;
      err_q           <= 1'b0;
    end else begin
      active_q        <= (active_q & ~arrivals) | released;
      release_valid_q <= rel_any;
      release_bid_q   <= rel_bid;
      err_q           <= req_err;
    end
  end

  assign active_mask   = active_q;
  assign barrier_busy  = busy_v;
  assign release_valid = release_valid_q;
  assign release_bid   = release_bid_q;
  assign stall         = (active_q == '0);
  assign err           = err_q;

endmodule

// File: tb/tb_gpu_convergence_barrier.sv
// tb/tb_gpu_convergence_barrier.sv - directed vector table plus randomized run against a reference model
module tb_gpu_convergence_barrier;
  import gpu_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         add_valid = 1'b0;
  logic [1:0]   add_bid = '0;
  logic [31:0]  add_mask = '0;
  logic         wait_valid = 1'b0;
  logic [1:0]   wait_bid = '0;
  logic [31:0]  wait_mask = '0;
  logic [31:0]  active_mask;
  logic [3:0]   barrier_busy;
  logic         release_valid;
  logic [1:0]   release_bid;
  logic         stall;
  logic         err;

  int checks = 0;
  int failures = 0;

  gpu_convergence_barrier dut (
    .clk           (clk),
    .reset         (reset),
    .add_valid     (add_valid),
    .add_bid       (add_bid),
    .add_mask      (add_mask),
    .wait_valid    (wait_valid),
    .wait_bid      (wait_bid),
    .wait_mask     (wait_mask),
    .active_mask   (active_mask),
    .barrier_busy  (barrier_busy),
    .release_valid (release_valid),
    .release_bid   (release_bid),
    .stall         (stall),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        av;
    logic [1:0]  ab;
    logic [31:0] am;
    logic        wv;
    logic [1:0]  wb;
    logic [31:0] wm;
    logic [31:0] e_active;
    logic [3:0]  e_busy;
    logic        e_rv;
    logic [1:0]  e_rbid;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  // reference model: armed flags, participants, arrivals, one pending release
  thread_mask_t m_active;
  thread_mask_t m_part [4];
  thread_mask_t m_got  [4];
  bit           m_armed[4];
  int           m_pend;
  bit           x_rv;
  int           x_rbid;
  bit           x_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic av, input logic [1:0] ab, input logic [31:0] am,
                       input logic wv, input logic [1:0] wb, input logic [31:0] wm);
    reset = rst; add_valid = av; add_bid = ab; add_mask = am;
    wait_valid = wv; wait_bid = wb; wait_mask = wm;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rst, input logic av, input logic [1:0] ab, input logic [31:0] am,
                              input logic wv, input logic [1:0] wb, input logic [31:0] wm,
                              input logic [31:0] ea, input logic [3:0] eb, input logic erv,
                              input logic [1:0] erb, input logic ee);
    vec_t v;
    v = '{rst, av, ab, am, wv, wb, wm, ea, eb, erv, erb, ee};
    return v;
  endfunction

  task automatic model_reset();
    m_active = '1;
    m_pend = -1;
    x_rv = 0; x_rbid = 0; x_err = 0;
    for (int b = 0; b < 4; b++) begin
      m_part[b] = '0; m_got[b] = '0; m_armed[b] = 0;
    end
  endtask

  task automatic model_step(input bit av, input int ab, input thread_mask_t am,
                            input bit wv, input int wb, input thread_mask_t wm);
    int old_pend, new_pend;
    thread_mask_t arr, rel;
    bit same, e;
    old_pend = m_pend; new_pend = -1; arr = '0; rel = '0; e = 0;
    same = av && wv && (ab == wb);
    if (old_pend >= 0) rel = m_part[old_pend];
    if (wv) begin
      if (same || !(m_armed[wb] || old_pend == wb)) e = 1;
      else if (m_armed[wb]) begin
        arr = wm & m_part[wb] & m_active;
        m_got[wb] = m_got[wb] | arr;
        if (m_got[wb] == m_part[wb]) begin
          m_armed[wb] = 0;
          new_pend = wb;
        end
      end
    end
    if (av) begin
      if (same || m_armed[ab] || old_pend == ab || new_pend == ab || (am & m_active) == '0) e = 1;
      else begin
        m_armed[ab] = 1;
        m_part[ab] = am & m_active;
        m_got[ab] = '0;
      end
    end
    if (old_pend >= 0) begin
      m_part[old_pend] = '0;
      m_got[old_pend] = '0;
    end
    m_pend = new_pend;
    m_active = (m_active & ~arr) | rel;
    x_rv = (old_pend >= 0);
    x_rbid = (old_pend >= 0) ? old_pend : 0;
    x_err = e;
  endtask

  function automatic logic [3:0] model_busy();
    logic [3:0] r;
    for (int b = 0; b < 4; b++) r[b] = m_armed[b] || (m_pend == b);
    return r;
  endfunction

  initial begin
    // reset and the basic full-warp barrier
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0,            32'hFFFFFFFF, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0,            32'hFFFFFFFF, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 0, 32'h0000FFFF, 32'hFFFF0000, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 0, 32'hFFFF0000, 32'h00000000, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0,            32'hFFFFFFFF, 4'b0000, 1, 0, 0));
    // divergent subset on bid1
    tbl.push_back(mk(0, 1, 1, 32'h000000FF, 0, 0, 0,            32'hFFFFFFFF, 4'b0010, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h0000000F, 32'hFFFFFFF0, 4'b0010, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h000000F0, 32'hFFFFFF00, 4'b0010, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0,            32'hFFFFFFFF, 4'b0000, 1, 1, 0));
    // errors: wait idle, add busy (part kept), same-bid add+wait
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 2, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0,            32'hFFFFFFFF, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0000000F, 0, 0, 0,            32'hFFFFFFFF, 4'b0001, 0, 0, 1));
    tbl.push_back(mk(0, 1, 3, 32'h000000FF, 1, 3, 32'h000000FF, 32'hFFFFFFFF, 4'b0001, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 0, 32'hFFFFFFFF, 32'h00000000, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0,            32'hFFFFFFFF, 4'b0000, 1, 0, 0));
    // nested: park on bid0 in the cycle bid1 is releasing
    tbl.push_back(mk(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0,            32'hFFFFFFFF, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h000000FF, 0, 0, 0,            32'hFFFFFFFF, 4'b0011, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h0000000F, 32'hFFFFFFF0, 4'b0011, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h000000F0, 32'hFFFFFF00, 4'b0011, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 0, 32'h0000FF00, 32'hFFFF00FF, 4'b0001, 1, 1, 0));
    // add and wait on different bids together
    tbl.push_back(mk(0, 1, 2, 32'hF0000000, 1, 0, 32'h00FF0000, 32'hFF0000FF, 4'b0101, 0, 0, 0));
    // reset while armed with parked lanes, no release afterwards
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 0, 32'hFF000000, 32'hFFFFFFFF, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0,            32'hFFFFFFFF, 4'b0000, 0, 0, 0));
    // add whose mask misses every active lane
    tbl.push_back(mk(0, 1, 1, 32'h00000000, 0, 0, 0,            32'hFFFFFFFF, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0,            32'hFFFFFFFF, 4'b0000, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].av, tbl[i].ab, tbl[i].am, tbl[i].wv, tbl[i].wb, tbl[i].wm);
      chk($sformatf("vec%0d_active", i), active_mask, tbl[i].e_active);
      chk($sformatf("vec%0d_busy", i), 32'(barrier_busy), 32'(tbl[i].e_busy));
      chk($sformatf("vec%0d_release_valid", i), 32'(release_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) chk($sformatf("vec%0d_release_bid", i), 32'(release_bid), 32'(tbl[i].e_rbid));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].e_err));
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].e_active == 32'h0));
    end

    drive(1, 0, 0, 0, 0, 0, 0);
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic rst, av, wv;
      logic [1:0] ab, wb;
      logic [31:0] am, wm;
      rst = ($urandom_range(0, 63) == 0);
      av = ($urandom_range(0, 2) == 0);
      wv = ($urandom_range(0, 1) == 0);
      ab = 2'($urandom_range(0, 3));
      wb = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: am = 32'hFFFFFFFF;
        1: am = 32'h0;
        2: am = 32'h000000FF << (8 * $urandom_range(0, 3));
        default: am = $urandom;
      endcase
      wm = ($urandom_range(0, 1) == 0) ? 32'hFFFFFFFF : $urandom;
      drive(rst, av, ab, am, wv, wb, wm);
      if (rst) model_reset();
      else model_step(av, int'(ab), am, wv, int'(wb), wm);
      chk("rnd_active", active_mask, m_active);
      chk("rnd_busy", 32'(barrier_busy), 32'(model_busy()));
      chk("rnd_release_valid", 32'(release_valid), 32'(x_rv));
      if (x_rv) chk("rnd_release_bid", 32'(release_bid), 32'(x_rbid));
      chk("rnd_err", 32'(err), 32'(x_err));
      chk("rnd_stall", 32'(stall), 32'(m_active == '0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
